// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bundle for im_loader.
// master: the host/test side that drives the stream.
// slave: the loader, which drives the write port and the status flags.
interface im_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_rdy;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, byte_in, byte_vld,
    input  byte_rdy, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_vld,
    output byte_rdy, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/im_loader.sv
// Program loader: consumes a big-endian byte stream made of a length header,
// N 16-bit instruction words and an XOR checksum, and writes each word into
// instruction memory. While busy is high the CPU is held in reset.
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input logic         clk,
  input logic         rst_n,
  im_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StChkHi,
    StChkLo,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] len_q;      // word count N from the header
  logic [15:0] idx_q;      // index of the next word to write
  logic [15:0] xor_q;      // running XOR of written words
  logic [7:0]  hi_q;       // high byte of the word or checksum in flight
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [15:0] wr_data_q;

  logic        xfer;
  logic [15:0] cur_word;
  logic [15:0] len_rx;

  // A byte is taken only when the loader is mid-stream; busy_q marks exactly
  // the states LEN_HI..CHK_LO, so it doubles as the ready flag.
  assign xfer     = bus.byte_vld & busy_q;
  assign cur_word = {hi_q, bus.byte_in};
  assign len_rx   = {len_q[15:8], bus.byte_in};

  // Loader state machine with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= 16'h0000;
      idx_q     <= 16'h0000;
      xor_q     <= 16'h0000;
      hi_q      <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 16'h0000;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold between writes.
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q <= StLenHi;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 16'h0000;
            xor_q   <= 16'h0000;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_q[15:8] <= bus.byte_in;
            state_q     <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q[7:0] <= bus.byte_in;
            state_q    <= (len_rx != 16'h0000) ? StDatHi : StChkHi;
          end
        end
        StDatHi: begin
          if (xfer) begin
            hi_q    <= bus.byte_in;
            state_q <= StDatLo;
          end
        end
        StDatLo: begin
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= BASE_ADDR + idx_q;  // wraps modulo 2^16
            wr_data_q <= cur_word;
            idx_q     <= idx_q + 16'd1;
            xor_q     <= xor_q ^ cur_word;
            // idx_q tops out at N-1 <= 65534, so idx_q + 1 never overflows here.
            state_q   <= (idx_q + 16'd1 == len_q) ? StChkHi : StDatHi;
          end
        end
        StChkHi: begin
          if (xfer) begin
            hi_q    <= bus.byte_in;
            state_q <= StChkLo;
          end
        end
        StChkLo: begin
          if (xfer) begin
            err_q   <= (cur_word != xor_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_rdy = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table-driven loads, hand-written corner
// sequences and randomized loads checked against a stream-level model.
module tb_im_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] wr_q_t[$];

  typedef struct {
    int          n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] chk;
    int          exp_writes;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_vld;
  int         sel;

  int tests_run;
  int tests_failed;
  int busy_cnt;

  wr_q_t wq0;
  wr_q_t wq1;

  im_loader_if if0 ();
  im_loader_if if1 ();

  im_loader #(.BASE_ADDR(16'h0000)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  im_loader #(.BASE_ADDR(16'hFFFF)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.start    = (sel == 0) ? start    : 1'b0;
  assign if0.byte_in  = (sel == 0) ? byte_in  : 8'h00;
  assign if0.byte_vld = (sel == 0) ? byte_vld : 1'b0;
  assign if1.start    = (sel == 1) ? start    : 1'b0;
  assign if1.byte_in  = (sel == 1) ? byte_in  : 8'h00;
  assign if1.byte_vld = (sel == 1) ? byte_vld : 1'b0;

  logic cur_rdy, cur_busy, cur_done, cur_err, cur_wr_en;
  logic [15:0] cur_addr, cur_data;
  assign cur_rdy   = (sel == 1) ? if1.byte_rdy : if0.byte_rdy;
  assign cur_busy  = (sel == 1) ? if1.busy     : if0.busy;
  assign cur_done  = (sel == 1) ? if1.done     : if0.done;
  assign cur_err   = (sel == 1) ? if1.err      : if0.err;
  assign cur_wr_en = (sel == 1) ? if1.wr_en    : if0.wr_en;
  assign cur_addr  = (sel == 1) ? if1.wr_addr  : if0.wr_addr;
  assign cur_data  = (sel == 1) ? if1.wr_data  : if0.wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side monitor: log every write strobe, count busy cycles.
  always @(negedge clk) begin
    if (if0.wr_en) wq0.push_back({if0.wr_addr, if0.wr_data});
    if (if1.wr_en) wq1.push_back({if1.wr_addr, if1.wr_data});
    if (cur_busy) busy_cnt++;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited   = 0;
    byte_in  = b;
    byte_vld = 1'b1;
    while (!cur_rdy && waited < 50) begin
      @(posedge clk);
      #1 waited++;
    end
    check("byte_rdy_wait", {31'd0, cur_rdy}, 32'd1);
    if (cur_rdy) begin
      @(posedge clk);
      #1;
    end
    if (gap > 0) begin
      byte_vld = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Full load on DUT s: start, stream all bytes, settle one cycle.
  task automatic do_load(input int s, input byte_q_t b, input int gap);
    sel      = s;
    busy_cnt = 0;
    if (s == 1) wq1.delete();
    else        wq0.delete();
    pulse_start();
    check("start_clears_done", {31'd0, cur_done}, 32'd0);
    check("start_clears_err",  {31'd0, cur_err},  32'd0);
    check("start_sets_busy",   {31'd0, cur_busy}, 32'd1);
    foreach (b[i]) send_byte(b[i], gap);
    byte_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Stream-level reference: decode header, words and checksum from the bytes.
  task automatic verify(input int s, input byte_q_t b, input string tag);
    int          n;
    logic [15:0] x, base, w, chk;
    wr_q_t       exp, got;
    base = (s == 1) ? 16'hFFFF : 16'h0000;
    n    = int'({b[0], b[1]});
    x    = 16'h0000;
    for (int i = 0; i < n; i++) begin
      w = {b[2 + 2 * i], b[3 + 2 * i]};
      x = x ^ w;
      exp.push_back({base + 16'(i), w});
    end
    chk = {b[2 + 2 * n], b[3 + 2 * n]};
    got = (s == 1) ? wq1 : wq0;
    check({tag, "_wr_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({tag, "_wr"}, got[i], exp[i]);
    check({tag, "_done"}, {31'd0, cur_done}, 32'd1);
    check({tag, "_busy"}, {31'd0, cur_busy}, 32'd0);
    check({tag, "_err"},  {31'd0, cur_err},  {31'd0, chk != x});
  endtask

  function automatic byte_q_t build(input int n, input logic [15:0] w[$], input logic [15:0] chk);
    byte_q_t b;
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
    end
    b.push_back(chk[15:8]);
    b.push_back(chk[7:0]);
    return b;
  endfunction

  vec_t        vecs[6];
  byte_q_t     bs;
  logic [15:0] wl[$];
  int          waited;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    busy_cnt     = 0;
    sel          = 0;
    start        = 1'b0;
    byte_in      = 8'h00;
    byte_vld     = 1'b0;
    rst_n        = 1'b0;

    vecs[0] = '{2, 16'hA123, 16'h0F0F, 16'h0000, 16'hAE2C, 2, 1'b0, 8};
    vecs[1] = '{2, 16'hA123, 16'h0F0F, 16'h0000, 16'hAE2D, 2, 1'b1, 8};
    vecs[2] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 4};
    vecs[3] = '{3, 16'h0001, 16'h0002, 16'h0004, 16'h0007, 3, 1'b0, 10};
    vecs[4] = '{1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1, 1'b0, 6};
    vecs[5] = '{1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 1'b1, 6};

    // Reset then idle with a byte offered: nothing may be consumed.
    do_reset();
    byte_in  = 8'h55;
    byte_vld = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_rdy",     {31'd0, if0.byte_rdy}, 32'd0);
    check("idle_busy",    {31'd0, if0.busy},     32'd0);
    check("idle_done",    {31'd0, if0.done},     32'd0);
    check("idle_err",     {31'd0, if0.err},      32'd0);
    check("idle_wr_en",   {31'd0, if0.wr_en},    32'd0);
    check("idle_wr_addr", {16'd0, if0.wr_addr},  32'd0);
    check("idle_wr_data", {16'd0, if0.wr_data},  32'd0);
    check("idle_writes",  wq0.size(),            32'd0);
    byte_vld = 1'b0;

    // Table-driven loads on BASE_ADDR = 0 with byte_vld held high.
    for (int k = 0; k < 6; k++) begin
      wl.delete();
      wl.push_back(vecs[k].w0);
      wl.push_back(vecs[k].w1);
      wl.push_back(vecs[k].w2);
      bs = build(vecs[k].n, wl, vecs[k].chk);
      do_load(0, bs, 0);
      check("vec_writes", wq0.size(), vecs[k].exp_writes);
      check("vec_err",    {31'd0, cur_err}, {31'd0, vecs[k].exp_err});
      check("vec_busy",   busy_cnt, vecs[k].exp_busy);
      verify(0, bs, "vec");
    end

    // Wrap and stall on BASE_ADDR = FFFF, 5 idle cycles between bytes.
    bs = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    do_load(1, bs, 5);
    check("wrap_count", wq1.size(), 32'd2);
    if (wq1.size() == 2) begin
      check("wrap_first",  wq1[0], 32'hFFFF_1111);
      check("wrap_second", wq1[1], 32'h0000_2222);
    end
    verify(1, bs, "wrap");

    // Start while busy is ignored; reset after the first write aborts.
    sel = 0;
    wq0.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    byte_vld = 1'b0;
    pulse_start();
    send_byte(8'hA1, 0);
    send_byte(8'h23, 0);
    byte_vld = 1'b0;
    waited = 0;
    while (wq0.size() == 0 && waited < 10) begin
      @(posedge clk);
      #1 waited++;
    end
    check("abort_first_write", wq0.size(), 32'd1);
    do_reset();
    #1;
    check("abort_busy", {31'd0, if0.busy},     32'd0);
    check("abort_done", {31'd0, if0.done},     32'd0);
    check("abort_rdy",  {31'd0, if0.byte_rdy}, 32'd0);
    byte_in  = 8'h0F;
    byte_vld = 1'b1;
    repeat (4) @(posedge clk);
    #1 byte_vld = 1'b0;
    check("abort_no_more_writes", wq0.size(), 32'd1);
    if (wq0.size() >= 1) check("abort_write", wq0[0], 32'h0000_A123);
    bs = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'h0F, 8'h0F, 8'hAE, 8'h2C};
    do_load(0, bs, 0);
    verify(0, bs, "after_abort");

    // Randomized loads on both DUTs.
    for (int k = 0; k < 24; k++) begin
      int          n, s, gap;
      logic [15:0] x, chk;
      s   = k % 2;
      n   = $urandom_range(0, 5);
      gap = $urandom_range(0, 2);
      wl.delete();
      x = 16'h0000;
      for (int i = 0; i < n; i++) begin
        wl.push_back(16'($urandom_range(0, 65535)));
        x = x ^ wl[i];
      end
      chk = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : x;
      bs  = build(n, wl, chk);
      do_load(s, bs, gap);
      verify(s, bs, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
